// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types and default widths for the two-port RAM arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default RAM geometry (32 x 8)
//   owner_t                 : which requester an access belongs to
//   ram_cmd_t               : one RAM command {we, addr, wdata}
//   rsp_tag_t               : per-command tag carried beside the RAM pipeline
package ram_arb_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } ram_cmd_t;

   typedef struct packed {
      logic   valid;
      logic   is_read;
      owner_t owner;
   } rsp_tag_t;

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr
// Two-way combinational grant logic for the RAM arbiter.
// Ports:
//   req_a, req_b   : requests (already masked by reset in the parent)
//   last_grant     : most recent winner, used to alternate on contention
//   gnt_a, gnt_b   : one-hot-or-zero grants
// Build option RAM_ARB_FIXED_PRIO_EN: when defined, A always wins contention
// and last_grant is ignored.
module ram_arb_rr
   import ram_arb_pkg::*;
(
   input  logic   req_a,
   input  logic   req_b,
   input  owner_t last_grant,
   output logic   gnt_a,
   output logic   gnt_b
);

`ifdef RAM_ARB_FIXED_PRIO_EN
   // A has absolute priority; B only wins when A is not asking.
   always_comb begin
      gnt_a = req_a;
      gnt_b = req_b & ~req_a;
   end
`else
   // On contention the requester that did not win last time goes next.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (req_a && req_b) begin
         if (last_grant == OWN_A) begin
            gnt_b = 1'b1;
         end else begin
            gnt_a = 1'b1;
         end
      end else begin
         gnt_a = req_a;
         gnt_b = req_b;
      end
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one synchronous single-port RAM between requesters A and B.
// Grant is combinational in cycle t, the RAM command is registered in t+1,
// read data is captured at the end of t+2 and returned with rvalid in t+3.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   req_x, we_x, addr_x, data_in_x    : request and command from requester x
//   gnt_x                             : request accepted this cycle
//   rvalid_x, data_out_x              : read response pulse / held read data
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata : RAM macro interface
// Build option RAM_ARB_FIXED_PRIO_EN: fixed priority (A wins) instead of
// round-robin, with last_grant tied to B and unused by the grant logic.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_in_a,
   input  logic [DATA_W-1:0] data_in_b,
   output logic              gnt_a,
   output logic              gnt_b,
   output logic              rvalid_a,
   output logic              rvalid_b,
   output logic [DATA_W-1:0] data_out_a,
   output logic [DATA_W-1:0] data_out_b,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   owner_t              last_grant;
   logic                accept;
   owner_t              sel_owner;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   rsp_tag_t            tag_cmd;
   rsp_tag_t            tag_rd;
   logic                cap_a;
   logic                cap_b;

   // Requests are masked while rst is high so no grant is issued in reset.
   ram_arb_rr u_rr (
      .req_a      (req_a & ~rst),
      .req_b      (req_b & ~rst),
      .last_grant (last_grant),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b)
   );

   // Select the winning requester's command.
   always_comb begin
      accept    = gnt_a | gnt_b;
      sel_owner = gnt_b ? OWN_B : OWN_A;
      sel_we    = gnt_b ? we_b : we_a;
      sel_addr  = gnt_b ? addr_b : addr_a;
      sel_wdata = gnt_b ? data_in_b : data_in_a;
   end

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign last_grant = OWN_B;
`else
   // Remember who won; reset to B so A wins the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= OWN_B;
      end else if (accept) begin
         last_grant <= sel_owner;
      end
   end
`endif

   // Command stage: one registered RAM command per accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_en    <= accept;
         ram_we    <= accept & sel_we;
         ram_addr  <= sel_addr;
         ram_wdata <= sel_wdata;
      end
   end

   // Tag pipeline: tag_cmd sits beside the RAM command, tag_rd beside the
   // cycle in which ram_rdata is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_cmd <= '0;
         tag_rd  <= '0;
      end else begin
         tag_cmd <= '{valid: accept, is_read: ~sel_we, owner: sel_owner};
         tag_rd  <= tag_cmd;
      end
   end

   assign cap_a = tag_rd.valid & tag_rd.is_read & (tag_rd.owner == OWN_A);
   assign cap_b = tag_rd.valid & tag_rd.is_read & (tag_rd.owner == OWN_B);

   // Response stage: steer read data to its owner and pulse rvalid once.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_a   <= 1'b0;
         rvalid_b   <= 1'b0;
         data_out_a <= '0;
         data_out_b <= '0;
      end else begin
         rvalid_a <= cap_a;
         rvalid_b <= cap_b;
         if (cap_a) begin
            data_out_a <= ram_rdata;
         end
         if (cap_b) begin
            data_out_b <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter: a behavioural RAM, a grant-order
// reference model with a per-cycle expectation schedule, a table of
// directed vectors, hand-written corner sequences and a random phase.
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   localparam int MAXC = 1024;

`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       req_a, req_b, we_a, we_b;
   logic [4:0] addr_a, addr_b;
   logic [7:0] data_in_a, data_in_b;
   logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [7:0] data_out_a, data_out_b;
   logic       ram_en, ram_we;
   logic [4:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata = 8'h00;
   logic [7:0] ram_mem [32] = '{default: 8'h00};

   ram_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .req_b      (req_b),
      .we_a       (we_a),
      .we_b       (we_b),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .data_in_a  (data_in_a),
      .data_in_b  (data_in_b),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b),
      .rvalid_a   (rvalid_a),
      .rvalid_b   (rvalid_b),
      .data_out_a (data_out_a),
      .data_out_b (data_out_b),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM macro stand-in.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   // Reference model state: memory image updated in grant order, the last
   // winner, and what each future cycle must show.
   logic [7:0] ref_mem [32] = '{default: 8'h00};
   bit         ref_last_b;
   bit         known;
   int         cyc;
   bit         sch_en [MAXC];
   bit         sch_we [MAXC];
   logic [4:0] sch_addr [MAXC];
   logic [7:0] sch_wd [MAXC];
   bit         sch_rva [MAXC];
   bit         sch_rvb [MAXC];
   logic [7:0] sch_da [MAXC];
   logic [7:0] sch_db [MAXC];
   logic [7:0] cur_da, cur_db;
   bit         exp_ga, exp_gb;
   int         errors;
   int         checks;

   typedef struct {
      bit       ra;
      ram_cmd_t ca;
      bit       rb;
      ram_cmd_t cb;
      bit       ega;
      bit       egb;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mkv(bit ra, bit wa, int aa, int da,
                                bit rb, bit wb, int ab, int db,
                                bit ega, bit egb);
      vec_t v;
      v.ra = ra;  v.ca.we = wa;  v.ca.addr = 5'(aa);  v.ca.wdata = 8'(da);
      v.rb = rb;  v.cb.we = wb;  v.cb.addr = 5'(ab);  v.cb.wdata = 8'(db);
      v.ega = ega;
      v.egb = egb;
      return v;
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic applyStimulus(bit r, bit ra, bit wa, logic [4:0] aa, logic [7:0] da,
                                bit rb, bit wb, logic [4:0] ab, logic [7:0] db);
      rst = r;
      req_a = ra;  we_a = wa;  addr_a = aa;  data_in_a = da;
      req_b = rb;  we_b = wb;  addr_b = ab;  data_in_b = db;
   endtask

   // Check the current cycle at the falling edge, then advance the model
   // across the next rising edge.
   task automatic stepCycle();
      bit         ga, gb, we;
      logic [4:0] addr;
      logic [7:0] wd;
      @(negedge clk);
      ga = 1'b0;
      gb = 1'b0;
      if (!rst) begin
         if (req_a && req_b) begin
            if (FIXED || ref_last_b) ga = 1'b1;
            else                     gb = 1'b1;
         end else begin
            ga = req_a;
            gb = req_b;
         end
      end
      exp_ga = ga;
      exp_gb = gb;
      checkOutput("gnt_a", gnt_a, ga);
      checkOutput("gnt_b", gnt_b, gb);
      if (known) begin
         if (sch_rva[cyc]) cur_da = sch_da[cyc];
         if (sch_rvb[cyc]) cur_db = sch_db[cyc];
         checkOutput("ram_en", ram_en, sch_en[cyc]);
         if (sch_en[cyc]) begin
            checkOutput("ram_we", ram_we, sch_we[cyc]);
            checkOutput("ram_addr", ram_addr, sch_addr[cyc]);
            if (sch_we[cyc]) checkOutput("ram_wdata", ram_wdata, sch_wd[cyc]);
         end
         checkOutput("rvalid_a", rvalid_a, sch_rva[cyc]);
         checkOutput("rvalid_b", rvalid_b, sch_rvb[cyc]);
         checkOutput("data_out_a", data_out_a, cur_da);
         checkOutput("data_out_b", data_out_b, cur_db);
      end
      if (rst) begin
         known      = 1'b1;
         ref_last_b = 1'b1;
         cur_da     = 8'h00;
         cur_db     = 8'h00;
         for (int k = 1; k <= 3; k++) begin
            if (cyc + k < MAXC) begin
               sch_en[cyc+k]  = 1'b0;
               sch_rva[cyc+k] = 1'b0;
               sch_rvb[cyc+k] = 1'b0;
            end
         end
      end else if (ga || gb) begin
         we   = ga ? we_a : we_b;
         addr = ga ? addr_a : addr_b;
         wd   = ga ? data_in_a : data_in_b;
         if (cyc + 3 < MAXC) begin
            sch_en[cyc+1]   = 1'b1;
            sch_we[cyc+1]   = we;
            sch_addr[cyc+1] = addr;
            sch_wd[cyc+1]   = wd;
            if (we) begin
               ref_mem[addr] = wd;
            end else if (ga) begin
               sch_rva[cyc+3] = 1'b1;
               sch_da[cyc+3]  = ref_mem[addr];
            end else begin
               sch_rvb[cyc+3] = 1'b1;
               sch_db[cyc+3]  = ref_mem[addr];
            end
         end
         ref_last_b = gb;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idleCycles(int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
         stepCycle();
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit         pa, pb, wa, wb;
      logic [4:0] aa, ab;
      logic [7:0] da, db;
      bit         r;
      errors = 0;
      checks = 0;
      cyc = 0;
      known = 1'b0;
      ref_last_b = 1'b1;
      cur_da = 8'h00;
      cur_db = 8'h00;
      applyStimulus(1, 1, 0, 5'd0, 8'h00, 1, 0, 5'd0, 8'h00);

      // Directed vectors, expected grants written out by hand.
      vecs[0] = mkv(1, 1, 3, 'h5A, 1, 1, 9, 'h33, 1, 0);
      vecs[1] = mkv(0, 0, 0, 0,    1, 1, 9, 'h33, 0, 1);
      vecs[2] = mkv(1, 0, 3, 0,    0, 0, 0, 0,    1, 0);
      for (int i = 3; i <= 5; i++) vecs[i] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[6] = mkv(0, 0, 0, 0,    1, 0, 9, 0,    0, 1);
      for (int k = 0; k < 6; k++) begin
         vecs[7+k] = mkv(1, 0, 3, 0, 1, 0, 9, 0,
                         FIXED ? 1'b1 : (k % 2 == 0), FIXED ? 1'b0 : (k % 2 == 1));
      end
      vecs[13] = mkv(0, 0, 0, 0,   1, 0, 9, 0,    0, 1);
      for (int i = 14; i <= 17; i++) vecs[i] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      @(posedge clk);
      #1;

      // Reset held 3 cycles with both requesters asking.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 5'd0, 8'h00, 1, 0, 5'd0, 8'h00);
         stepCycle();
         if (i < 2) begin
            checkOutput("rst_ram_addr", ram_addr, 0);
            checkOutput("rst_ram_wdata", ram_wdata, 0);
            checkOutput("rst_ram_we", ram_we, 0);
         end
      end

      for (int i = 0; i < 18; i++) begin
         applyStimulus(0, vecs[i].ra, vecs[i].ca.we, vecs[i].ca.addr, vecs[i].ca.wdata,
                       vecs[i].rb, vecs[i].cb.we, vecs[i].cb.addr, vecs[i].cb.wdata);
         #3;
         checkOutput("tbl_gnt_a", gnt_a, vecs[i].ega);
         checkOutput("tbl_gnt_b", gnt_b, vecs[i].egb);
         stepCycle();
      end
      checkOutput("single_dout_a", data_out_a, 8'h5A);
      checkOutput("single_dout_b", data_out_b, 8'h33);

      // A write and B read to the same address in the same cycle.
      applyStimulus(0, 1, 1, 5'd7, 8'h11, 1, 0, 5'd7, 8'h00);
      #3;
      checkOutput("ord_gnt_a", gnt_a, 1);
      stepCycle();
      applyStimulus(0, 0, 0, 5'd0, 8'h00, 1, 0, 5'd7, 8'h00);
      stepCycle();
      idleCycles(4);
      checkOutput("ord_new_dout_b", data_out_b, 8'h11);

      // Reverse: A reads first, B's write lands afterwards.
      applyStimulus(0, 1, 0, 5'd7, 8'h00, 1, 1, 5'd7, 8'h22);
      stepCycle();
      applyStimulus(0, 0, 0, 5'd0, 8'h00, 1, 1, 5'd7, 8'h22);
      stepCycle();
      idleCycles(4);
      checkOutput("ord_old_dout_a", data_out_a, 8'h11);

      // Reset one cycle after a read is granted: the response is dropped.
      applyStimulus(0, 1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
      stepCycle();
      applyStimulus(1, 0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
      stepCycle();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
         stepCycle();
         checkOutput("midrst_rvalid_a", rvalid_a, 0);
         checkOutput("midrst_dout_a", data_out_a, 0);
      end

      // Random traffic with the request/grant handshake honoured.
      pa = 1'b0;
      pb = 1'b0;
      wa = 1'b0; wb = 1'b0; aa = '0; ab = '0; da = '0; db = '0;
      for (int n = 0; n < 400; n++) begin
         if (!pa && $urandom_range(0, 2) != 0) begin
            pa = 1'b1;
            wa = 1'($urandom_range(0, 1));
            aa = 5'($urandom_range(0, 7));
            da = 8'($urandom);
         end
         if (!pb && $urandom_range(0, 2) != 0) begin
            pb = 1'b1;
            wb = 1'($urandom_range(0, 1));
            ab = 5'($urandom_range(0, 7));
            db = 8'($urandom);
         end
         r = ($urandom_range(0, 49) == 0);
         applyStimulus(r, pa, wa, aa, da, pb, wb, ab, db);
         stepCycle();
         if (exp_ga) pa = 1'b0;
         if (exp_gb) pb = 1'b0;
      end
      idleCycles(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

- Shares one synchronous single-port RAM (32 x 8 by default) between two requesters, A and B.
- Arbitrates with a round-robin policy, issues one registered RAM command per cycle, and returns read data to the requester that issued the read.
- Sits between the two client blocks and the RAM macro. The RAM keeps no arbitration logic of its own.

## Interface
Parameters:
- ADDR_W, 5, RAM address width (depth 2**ADDR_W)
- DATA_W, 8, RAM data width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_a / req_b  in  1  requester wants an access
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  access address
- data_in_a / data_in_b  in  DATA_W  write data
- gnt_a / gnt_b  out  1  request accepted this cycle (combinational from req and priority)
- rvalid_a / rvalid_b  out  1  read data valid, one-cycle pulse
- data_out_a / data_out_b  out  DATA_W  read data, held until the next rvalid for that port
- ram_en  out  1  RAM command strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0

## Operation
- Handshake: a requester holds req, we, addr and data_in stable until it sees gnt high on a rising edge; the transfer happens on that edge.
- At most one of gnt_a and gnt_b is high in any cycle.
- gnt is never high without the matching req.
- Arbitration: a 1-bit last_grant register tracks the most recent winner.
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: the requester other than last_grant is granted.
  - last_grant updates only on a grant.
- Throughput: one accepted access per cycle, with no idle cycles.
- Command stage (cycle t+1 after acceptance at t): ram_en=1, and ram_we, ram_addr and ram_wdata come from the granted requester's registered command. With no grant, ram_en=0.
- Response stage:
  - A 2-deep tag pipeline carries {valid, is_read, owner} alongside each command.
  - At t+2, ram_rdata is captured into data_out_x of the owner.
  - rvalid_x pulses at t+3, one cycle wide.
  - Writes produce no rvalid.
- Ordering:
  - Accesses reach the RAM in grant order.
  - A write by A granted before a read by B to the same address returns the new data to B, and the reverse order returns the old data.
- There is no response backpressure. Requesters must accept rvalid when it pulses.
- Reset:
  - All outputs go to 0 (gnt_*, rvalid_*, data_out_*, ram_*).
  - last_grant = B, so A wins the first contention.
  - The tag pipeline is cleared.
- Reset mid-operation: in-flight commands and responses are dropped. No rvalid is issued for them after rst deasserts.

## Timing
- Grant: combinational in cycle t.
- RAM command: registered, cycle t+1.
- Read data: registered; data_out_x and rvalid_x visible in cycle t+3, i.e. read latency 3 cycles from grant.
- Back-to-back reads alternating between A and B yield rvalid pulses alternating every cycle.
- Combinational paths are limited to req -> gnt only.

## Configuration
- RAM_ARB_FIXED_PRIO_EN defined: fixed priority, with A always winning contention. last_grant is not implemented, and B can starve while A holds req.
- RAM_ARB_FIXED_PRIO_EN undefined (default): round-robin as described in Operation.
- All other behaviour and timing are identical in both configurations.

## Structure
- Package ram_arb_pkg holds:
  - default ADDR_W and DATA_W localparams
  - enum owner_t {OWN_A, OWN_B}
  - packed struct ram_cmd_t {we, addr, wdata}
  - packed struct rsp_tag_t {valid, is_read, owner_t owner}
- Sub-module ram_arb_rr implements the 2-way grant logic:
  - inputs: req pair, last_grant
  - outputs: gnt pair
  - contains the RAM_ARB_FIXED_PRIO_EN branch
- ram_arbiter instantiates ram_arb_rr and holds the command register, tag pipeline, response registers and last_grant.

## Test plan
- Reset: hold rst 3 cycles with req_a=req_b=1 -> every output 0 during reset; first cycle after reset gives gnt_a=1, gnt_b=0.
- Single requester: A writes 0x5A to addr 3, then reads addr 3 -> ram_en/ram_we=1/ram_addr=3 at t+1; rvalid_a at t_read+3 with data_out_a=0x5A; rvalid_b never pulses.
- Contention: req_a=req_b=1 held for 6 cycles, all reads -> grants alternate A,B,A,B,A,B; ram_en high all 6 command cycles.
- Ordering: A writes 0x11 to addr 7 and B reads addr 7 in the same cycle (A wins) -> data_out_b=0x11 after B's rvalid.
- Reset mid-flight: A read granted, rst asserted at t+1 for 1 cycle -> rvalid_a never pulses and data_out_a stays 0.
- Fixed priority build (RAM_ARB_FIXED_PRIO_EN defined): req_a=req_b=1 for 5 cycles -> gnt_a all 5 cycles, gnt_b=0; B is granted in the first cycle req_a drops.
